control_sequencer: RTL and testbench

- Multi-cycle fetch/decode/execute controller for the accumulator machine (ACC, MAR, MBR, IR, PC registers, ALU, MainMemory).
- Consumes the IR contents and the ACC value, and produces every register write enable, datapath mux select, ALU opcode and memory write strobe.
- Sits directly upstream of the Register instances and the ALU: it decides what they capture each clock.
- All outputs are Moore outputs, decoded from the state only. The target register captures on the clock edge that ends the state.

---
 rtl/control_sequencer.sv | 224 ++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle fetch/decode/execute controller for the
// accumulator machine. It reads IR and ACC and drives every register
// enable, datapath select, ALU opcode and the memory write strobe.
// All outputs are Moore outputs. They are registered from the next state, so
// each output is valid for the whole state it belongs to. The target register
// captures on the edge that ends that state.
module control_sequencer #(
  parameter int READ_WAIT = 1,
  parameter int ADDR_W    = 12
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic [15:0] ir,
  input  logic [15:0] acc,
  output logic        write_mar,
  output logic        mar_sel,
  output logic        write_ir,
  output logic        write_mbr,
  output logic        mbr_sel,
  output logic        write_acc,
  output logic [1:0]  acc_sel,
  output logic [3:0]  alu_opcode,
  output logic        write_pc,
  output logic        pc_sel,
  output logic        mem_write,
  output logic        halted,
  output logic        illegal,
  output logic [15:0] retired
);

  // Wait counter counts down from READ_WAIT-1 to zero inside a wait state.
  localparam int CNT_W = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(READ_WAIT - 1);
  // Skip condition lives in the top two bits of the address field.
  localparam int COND_HI = ADDR_W - 1;

  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUBT  = 4'h4;
  localparam logic [3:0] OP_HALT  = 4'h7;
  localparam logic [3:0] OP_SKIP  = 4'h8;
  localparam logic [3:0] OP_JUMP  = 4'h9;
  localparam logic [3:0] OP_CLEAR = 4'hA;

  typedef enum logic [3:0] {
    S_IDLE, S_F_ADDR, S_F_WAIT, S_F_IR, S_DECODE,
    S_E_ADDR, S_E_WAIT, S_E_MBR, S_E_ACC,
    S_S_ADDR, S_S_MBR, S_S_WR,
    S_E_JMP, S_E_SKIP, S_E_CLR, S_HALT
  } state_t;

  typedef struct packed {
    logic       write_mar;
    logic       mar_sel;
    logic       write_ir;
    logic       write_mbr;
    logic       mbr_sel;
    logic       write_acc;
    logic [1:0] acc_sel;
    logic [3:0] alu_opcode;
    logic       write_pc;
    logic       pc_sel;
    logic       mem_write;
    logic       halted;
  } ctl_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] wait_cnt_reg;
  ctl_t             ctl_reg, ctl_next;
  logic [15:0]      retired_reg;
  logic             illegal_reg;

  logic [3:0] opcode;
  logic       opcode_legal;
  logic       skip_taken;
  logic       entering_wait;
  logic       retire_now;
  logic       unused_addr_bits;

  assign opcode = ir[15:12];
  // The low address bits only matter to the datapath, not to sequencing.
  assign unused_addr_bits = ^ir[COND_HI-2:0];

  // Classify the opcode and evaluate the SKIPCOND test against ACC.
  always_comb begin
    opcode_legal = 1'b0;
    case (opcode)
      OP_LOAD, OP_STORE, OP_ADD, OP_SUBT,
      OP_HALT, OP_SKIP, OP_JUMP, OP_CLEAR: opcode_legal = 1'b1;
      default:                             opcode_legal = 1'b0;
    endcase
    skip_taken = 1'b0;
    case (ir[COND_HI -: 2])
      2'b00:   skip_taken = acc[15];
      2'b01:   skip_taken = (acc == 16'h0000);
      2'b10:   skip_taken = !acc[15] && (acc != 16'h0000);
      default: skip_taken = 1'b0;
    endcase
  end

  // Next-state selection for the instruction cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (run) state_next = S_F_ADDR;
      S_F_ADDR: state_next = S_F_WAIT;
      S_F_WAIT: if (wait_cnt_reg == '0) state_next = S_F_IR;
      S_F_IR:   state_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_ADD, OP_SUBT: state_next = S_E_ADDR;
          OP_STORE:                 state_next = S_S_ADDR;
          OP_JUMP:                  state_next = S_E_JMP;
          OP_SKIP:                  state_next = S_E_SKIP;
          OP_CLEAR:                 state_next = S_E_CLR;
          default:                  state_next = S_HALT;
        endcase
      end
      S_E_ADDR: state_next = S_E_WAIT;
      S_E_WAIT: if (wait_cnt_reg == '0) state_next = S_E_MBR;
      S_E_MBR:  state_next = S_E_ACC;
      S_E_ACC:  state_next = S_F_ADDR;
      S_S_ADDR: state_next = S_S_MBR;
      S_S_MBR:  state_next = S_S_WR;
      S_S_WR:   state_next = S_F_ADDR;
      S_E_JMP, S_E_SKIP, S_E_CLR: state_next = S_F_ADDR;
      S_HALT:   state_next = S_HALT;
      default:  state_next = S_IDLE;
    endcase
  end

  // Decode the control word for the state being entered, so it is registered
  // and stable throughout that state. IR and ACC do not change between the
  // decision and the state that uses it.
  always_comb begin
    ctl_next = '0;
    case (state_next)
      S_F_ADDR: ctl_next.write_mar = 1'b1;
      S_F_IR: begin
        ctl_next.write_ir = 1'b1;
        ctl_next.write_pc = 1'b1;
      end
      S_E_ADDR, S_S_ADDR: begin
        ctl_next.write_mar = 1'b1;
        ctl_next.mar_sel   = 1'b1;
      end
      S_E_MBR: ctl_next.write_mbr = 1'b1;
      S_E_ACC: begin
        ctl_next.write_acc = 1'b1;
        if (opcode == OP_LOAD) ctl_next.acc_sel = 2'b01;
        if (opcode == OP_SUBT) ctl_next.alu_opcode = 4'b0001;
      end
      S_S_MBR: begin
        ctl_next.write_mbr = 1'b1;
        ctl_next.mbr_sel   = 1'b1;
      end
      S_S_WR: ctl_next.mem_write = 1'b1;
      S_E_JMP: begin
        ctl_next.write_pc = 1'b1;
        ctl_next.pc_sel   = 1'b1;
      end
      S_E_SKIP: ctl_next.write_pc = skip_taken;
      S_E_CLR: begin
        ctl_next.write_acc = 1'b1;
        ctl_next.acc_sel   = 2'b10;
      end
      S_HALT: ctl_next.halted = 1'b1;
      default: ;
    endcase
  end

  // A wait counter load happens on entry to either read-wait state.
  assign entering_wait = ((state_next == S_F_WAIT) && (state_reg != S_F_WAIT)) ||
                         ((state_next == S_E_WAIT) && (state_reg != S_E_WAIT));

  // An instruction retires in its last cycle; HALT retires on entry to HALT.
  assign retire_now = ((state_next == S_F_ADDR) && (state_reg != S_IDLE)) ||
                      ((state_reg == S_DECODE) && (opcode == OP_HALT));

  // State, wait counter, control word, retire count and sticky illegal flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      wait_cnt_reg <= '0;
      ctl_reg      <= '0;
      retired_reg  <= 16'h0000;
      illegal_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      ctl_reg   <= ctl_next;
      if (entering_wait) begin
        wait_cnt_reg <= WAIT_LOAD;
      end else if (wait_cnt_reg != '0) begin
        wait_cnt_reg <= wait_cnt_reg - CNT_W'(1);
      end
      if (retire_now) begin
        retired_reg <= retired_reg + 16'h0001;
      end
      if ((state_reg == S_DECODE) && !opcode_legal) begin
        illegal_reg <= 1'b1;
      end
    end
  end

  // Strobes are masked by reset so a write already in flight (e.g. in S_WR)
  // never reaches the memory in the cycle reset is asserted.
  assign write_mar  = ctl_reg.write_mar & ~reset;
  assign write_ir   = ctl_reg.write_ir  & ~reset;
  assign write_mbr  = ctl_reg.write_mbr & ~reset;
  assign write_acc  = ctl_reg.write_acc & ~reset;
  assign write_pc   = ctl_reg.write_pc  & ~reset;
  assign mem_write  = ctl_reg.mem_write & ~reset;
  assign mar_sel    = ctl_reg.mar_sel;
  assign mbr_sel    = ctl_reg.mbr_sel;
  assign acc_sel    = ctl_reg.acc_sel;
  assign alu_opcode = ctl_reg.alu_opcode;
  assign pc_sel     = ctl_reg.pc_sel;
  assign halted     = ctl_reg.halted;
  assign illegal    = illegal_reg;
  assign retired    = retired_reg;

endmodule

// File: tb/tb_control_sequencer.sv
// Testbench for control_sequencer. A small accumulator-machine datapath
// (registers plus memory) is driven by the DUT strobes. An instruction-level
// model produces the expected per-cycle control trace from the instruction
// semantics and cycle templates.
module tb_control_sequencer;

  typedef struct packed {
    logic        write_mar;
    logic        mar_sel;
    logic        write_ir;
    logic        write_mbr;
    logic        mbr_sel;
    logic        write_acc;
    logic [1:0]  acc_sel;
    logic [3:0]  alu_opcode;
    logic        write_pc;
    logic        pc_sel;
    logic        mem_write;
    logic        halted;
    logic        illegal;
    logic [15:0] retired;
  } outs_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_v [2];
  logic        run_v   [2];
  logic [15:0] ir, acc, pc, mar, mbr;
  logic [15:0] mem  [256];
  logic [15:0] mmem [256];
  logic [15:0] mpc, macc, mret;
  logic        mill;
  outs_t       exp_q [$];
  outs_t       dut_o [2];
  int          sel;
  int          checks = 0;
  int          errors = 0;

  // Instance 0 uses READ_WAIT=1, instance 1 uses READ_WAIT=3.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      logic        w_mar, m_sel, w_ir, w_mbr, b_sel, w_acc, w_pc, p_sel, m_wr, hlt, ill;
      logic [1:0]  a_sel;
      logic [3:0]  alu;
      logic [15:0] ret;
      control_sequencer #(.READ_WAIT(gi == 0 ? 1 : 3), .ADDR_W(12)) u_dut (
        .clock(clock), .reset(reset_v[gi]), .run(run_v[gi]), .ir(ir), .acc(acc),
        .write_mar(w_mar), .mar_sel(m_sel), .write_ir(w_ir), .write_mbr(w_mbr),
        .mbr_sel(b_sel), .write_acc(w_acc), .acc_sel(a_sel), .alu_opcode(alu),
        .write_pc(w_pc), .pc_sel(p_sel), .mem_write(m_wr), .halted(hlt),
        .illegal(ill), .retired(ret)
      );
      assign dut_o[gi] = {w_mar, m_sel, w_ir, w_mbr, b_sel, w_acc, a_sel, alu,
                          w_pc, p_sel, m_wr, hlt, ill, ret};
    end
  endgenerate

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_o(input string name, input outs_t act, input outs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock of the datapath: capture what the selected DUT asks for.
  task automatic step();
    outs_t o;
    logic [15:0] n_mar, n_ir, n_mbr, n_acc, n_pc, wd;
    logic [7:0]  wa;
    logic        wr;
    #1;
    o = dut_o[sel];
    n_mar = mar; n_ir = ir; n_mbr = mbr; n_acc = acc; n_pc = pc;
    if (o.write_mar) n_mar = o.mar_sel ? {4'h0, ir[11:0]} : pc;
    if (o.write_ir)  n_ir  = mem[mar[7:0]];
    if (o.write_mbr) n_mbr = o.mbr_sel ? acc : mem[mar[7:0]];
    if (o.write_acc) begin
      case (o.acc_sel)
        2'b00:   n_acc = (o.alu_opcode == 4'd1) ? acc - mbr : acc + mbr;
        2'b01:   n_acc = mbr;
        default: n_acc = 16'h0000;
      endcase
    end
    if (o.write_pc) n_pc = o.pc_sel ? {4'h0, ir[11:0]} : pc + 16'h0001;
    wr = o.mem_write; wa = mar[7:0]; wd = mbr;
    @(posedge clock);
    #1;
    mar = n_mar; ir = n_ir; mbr = n_mbr; acc = n_acc; pc = n_pc;
    if (wr) mem[wa] = wd;
  endtask

  task automatic init_env(input logic [15:0] acc0);
    pc = 16'h0000; acc = acc0; mar = 16'h0000; mbr = 16'h0000; ir = 16'h0000;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
  endtask

  task automatic restart();
    reset_v[sel] = 1'b1;
    step();
    reset_v[sel] = 1'b0;
    step();
  endtask

  task automatic push(input outs_t o);
    outs_t t;
    t = o;
    t.retired = mret;
    exp_q.push_back(t);
  endtask

  // Instruction-level model: interprets the program in memory and emits the
  // control word expected in each cycle, starting with the first fetch.
  task automatic build_trace(input int rw);
    outs_t o;
    logic [15:0] w, a;
    logic [3:0]  op;
    bit done, t;
    int n;
    mmem = mem; mpc = pc; macc = acc; mret = 16'h0000; mill = 1'b0;
    exp_q.delete();
    done = 0; n = 0;
    while (!done) begin
      o = '0; o.write_mar = 1'b1; push(o);
      repeat (rw) begin o = '0; push(o); end
      o = '0; o.write_ir = 1'b1; o.write_pc = 1'b1; push(o);
      w = mmem[mpc[7:0]]; mpc = mpc + 16'h0001;
      o = '0; push(o);
      op = w[15:12];
      a = {4'h0, w[11:0]};
      case (op)
        4'h1, 4'h3, 4'h4: begin
          o = '0; o.write_mar = 1'b1; o.mar_sel = 1'b1; push(o);
          repeat (rw) begin o = '0; push(o); end
          o = '0; o.write_mbr = 1'b1; push(o);
          o = '0; o.write_acc = 1'b1;
          if (op == 4'h1) begin
            o.acc_sel = 2'b01; macc = mmem[a[7:0]];
          end else if (op == 4'h3) begin
            macc = macc + mmem[a[7:0]];
          end else begin
            o.alu_opcode = 4'd1; macc = macc - mmem[a[7:0]];
          end
          push(o);
        end
        4'h2: begin
          o = '0; o.write_mar = 1'b1; o.mar_sel = 1'b1; push(o);
          o = '0; o.write_mbr = 1'b1; o.mbr_sel = 1'b1; push(o);
          o = '0; o.mem_write = 1'b1; push(o);
          mmem[a[7:0]] = macc;
        end
        4'h9: begin
          o = '0; o.write_pc = 1'b1; o.pc_sel = 1'b1; push(o);
          mpc = a;
        end
        4'h8: begin
          case (w[11:10])
            2'b00:   t = $signed(macc) < 0;
            2'b01:   t = (macc == 16'h0000);
            2'b10:   t = $signed(macc) > 0;
            default: t = 0;
          endcase
          o = '0; o.write_pc = t; push(o);
          if (t) mpc = mpc + 16'h0001;
        end
        4'hA: begin
          o = '0; o.write_acc = 1'b1; o.acc_sel = 2'b10; push(o);
          macc = 16'h0000;
        end
        4'h7: begin
          mret = mret + 16'h0001; done = 1;
        end
        default: begin
          mill = 1'b1; done = 1;
        end
      endcase
      if (!done) mret = mret + 16'h0001;
      n++;
      if (n >= 64) done = 1;
    end
  endtask

  // Start the selected DUT and compare its outputs with the model every cycle.
  task automatic run_check(input int rw, input int exp_len, input string tag);
    outs_t h;
    build_trace(rw);
    chk({tag, " trace length"}, 16'(exp_q.size()), 16'(exp_len));
    run_v[sel] = 1'b1;
    step();
    run_v[sel] = 1'b0;
    foreach (exp_q[i]) begin
      chk_o($sformatf("%s cycle %0d", tag, i), dut_o[sel], exp_q[i]);
      step();
    end
    h = '0; h.halted = 1'b1; h.illegal = mill; h.retired = mret;
    repeat (2) begin
      chk_o({tag, " halt state"}, dut_o[sel], h);
      step();
    end
    $display("%s: %0d cycles to HALT, retired=%0d acc=%h pc=%h", tag, exp_q.size(), mret, acc, pc);
  endtask

  initial begin
    outs_t h;
    bit found;
    sel = 0;
    reset_v[0] = 1'b1; reset_v[1] = 1'b1;
    run_v[0] = 1'b0;   run_v[1] = 1'b0;
    init_env(16'h0000);
    repeat (2) step();
    reset_v[0] = 1'b0;
    step();
    chk_o("reset outputs", dut_o[0], '0);
    step();
    chk_o("idle without run", dut_o[0], '0);

    // HALT as the first instruction.
    init_env(16'h0000);
    mem[0] = 16'h7000;
    run_check(1, 4, "halt");
    chk("halt retired", dut_o[0].retired, 16'h0001);
    chk("halt halted", 16'(dut_o[0].halted), 16'h0001);
    chk("halt illegal", 16'(dut_o[0].illegal), 16'h0000);

    // LOAD; ADD; STORE; HALT.
    restart();
    init_env(16'h0000);
    mem[0] = 16'h1010; mem[1] = 16'h3011; mem[2] = 16'h2012; mem[3] = 16'h7000;
    mem[16'h10] = 16'h0005; mem[16'h11] = 16'h0007;
    run_check(1, 27, "prog");
    chk("prog store result", mem[16'h12], 16'h000C);
    chk("prog retired", dut_o[0].retired, 16'h0004);

    // SKIPCOND acc==0: taken, then not taken; acc<0 with 8000h.
    restart();
    init_env(16'h0000);
    mem[0] = 16'h8400; mem[1] = 16'h7000; mem[2] = 16'h7000;
    run_check(1, 9, "skip_eq_taken");
    chk("skip taken pc", pc, 16'h0003);
    restart();
    init_env(16'h0001);
    mem[0] = 16'h8400; mem[1] = 16'h7000; mem[2] = 16'h7000;
    run_check(1, 9, "skip_eq_not");
    chk("skip not taken pc", pc, 16'h0002);
    restart();
    init_env(16'h8000);
    mem[0] = 16'h8000; mem[1] = 16'h7000; mem[2] = 16'h7000;
    run_check(1, 9, "skip_neg");
    chk("skip 8000h negative pc", pc, 16'h0003);

    // JUMP 020h then SUBT with acc=3, mem=5.
    restart();
    init_env(16'h0003);
    mem[0] = 16'h9020; mem[16'h20] = 16'h4030; mem[16'h21] = 16'h7000; mem[16'h30] = 16'h0005;
    run_check(1, 17, "jump_subt");
    chk("subt result", acc, 16'hFFFE);
    chk("jump pc", pc, 16'h0022);

    // Illegal opcode, run ignored in HALT, reset clears the flags.
    restart();
    init_env(16'h0000);
    mem[0] = 16'hF000;
    run_check(1, 4, "illegal");
    chk("illegal flag", 16'(dut_o[0].illegal), 16'h0001);
    chk("illegal retired", dut_o[0].retired, 16'h0000);
    run_v[0] = 1'b1;
    step();
    run_v[0] = 1'b0;
    step();
    h = '0; h.halted = 1'b1; h.illegal = 1'b1;
    chk_o("run in halt ignored", dut_o[0], h);
    reset_v[0] = 1'b1;
    step();
    reset_v[0] = 1'b0;
    chk("reset clears halted/illegal", {14'h0, dut_o[0].halted, dut_o[0].illegal}, 16'h0000);
    step();
    chk_o("idle after flag reset", dut_o[0], '0);

    // Reset while in S_WR drops the write.
    init_env(16'h1234);
    mem[0] = 16'h2040; mem[1] = 16'h7000;
    run_v[0] = 1'b1;
    step();
    run_v[0] = 1'b0;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (dut_o[0].mem_write) begin
        found = 1;
        break;
      end
      step();
    end
    chk("reach store write", 16'(found), 16'h0001);
    reset_v[0] = 1'b1;
    #1;
    chk("mem_write dropped by reset", 16'(dut_o[0].mem_write), 16'h0000);
    step();
    chk_o("idle after reset in S_WR", dut_o[0], '0);
    chk("store suppressed", mem[16'h40], 16'h0000);
    reset_v[0] = 1'b0;
    step();
    chk_o("idle stays idle", dut_o[0], '0);

    // READ_WAIT=3 instance: LOAD (12 cycles) then HALT (6 cycles).
    reset_v[0] = 1'b1;
    sel = 1;
    reset_v[1] = 1'b0;
    step();
    init_env(16'h0000);
    mem[0] = 16'h1010; mem[1] = 16'h7000; mem[16'h10] = 16'hABCD;
    run_check(3, 18, "rw3");
    chk("rw3 load result", acc, 16'hABCD);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
